sdram_arbiter: RTL and testbench
================================

# sdram_arbiter

Two-requester arbiter in front of `sdram_controller`, sharing its single SoC-side command port between two masters (m0, m1; e.g. CPU and DMA/video). Each request is registered, issued to the controller as a one-cycle command pulse, and routed back to its owner on completion. One transaction is outstanding at a time. A watchdog flags controller hangs.

## Interface
- `ADDR_WIDTH`, 23: word address width (8M x 32-bit).
- `DATA_WIDTH`, 32: data width.
- `MASK_WIDTH`, 4: byte-mask width.
- `TIMEOUT_CYCLES`, 1024: maximum cycles from issue to controller `ready` (must be ≥ 2).
- `clk` in 1: single clock for the whole block.
- `reset_n_port` in 1: reset, asynchronous assert, active-low.
- `m<n>_addr_port` in ADDR_WIDTH: request address, n = 0 and n = 1 (two copies of every `m<n>` port).
- `m<n>_wr_data_port` in DATA_WIDTH: write data.
- `m<n>_wr_mask_port` in MASK_WIDTH: byte mask, passed through unchanged.
- `m<n>_wr_en_port` in 1: write request; a level, held until ack.
- `m<n>_rd_en_port` in 1: read request; a level, held until ack.
- `m<n>_ack_port` out 1: one-cycle pulse when the request is issued. The master may change its inputs the next cycle.
- `m<n>_ready_port` out 1: one-cycle completion pulse.
- `m<n>_rd_data_port` out DATA_WIDTH: read data, valid while `m<n>_ready_port` is high. Holds its value otherwise.
- `soc_side_busy_port` in 1: controller cannot accept a command.
- `soc_side_ready_port` in 1: controller completion pulse (read or write).
- `soc_side_rd_data_port` in DATA_WIDTH: controller read data, valid with ready.
- `soc_side_addr_port` out ADDR_WIDTH: command address, registered.
- `soc_side_wr_data_port` out DATA_WIDTH: command write data, registered.
- `soc_side_wr_mask_port` out MASK_WIDTH: command byte mask, registered.
- `soc_side_wr_en_port` out 1: one-cycle write command pulse.
- `soc_side_rd_en_port` out 1: one-cycle read command pulse.
- `timeout_err_port` out 1: sticky watchdog flag.

## Operation
- **States**
  - IDLE → ISSUE: when `soc_side_busy_port` = 0 and at least one master requests.
  - ISSUE → WAIT_DONE: unconditional, after one cycle.
  - WAIT_DONE → IDLE: on `soc_side_ready_port`, or on watchdog expiry.
- **IDLE.** Select the winner and latch the `owner` bit. Register addr, data, mask and direction into the controller-side output registers.
- **Direction.** If a master asserts both wr_en and rd_en, the request is treated as a write.
- **ISSUE.**
  - Assert exactly one of `soc_side_wr_en_port` / `soc_side_rd_en_port` for this cycle only.
  - Pulse `m<owner>_ack_port` in the same cycle.
  - Clear the watchdog counter.
- **WAIT_DONE.**
  - Increment the watchdog counter each cycle.
  - On `soc_side_ready_port` = 1: capture `soc_side_rd_data_port` into `m<owner>_rd_data_port`, pulse `m<owner>_ready_port` next cycle, go to IDLE.
  - Writes also pulse ready; their rd_data value is don't-care but must be unchanged.
- **Watchdog.** When the counter reaches TIMEOUT_CYCLES−1 without ready:
  - Set `timeout_err_port`.
  - Pulse `m<owner>_ready_port` with rd_data = 0.
  - Go to IDLE.
  - `timeout_err_port` clears only on reset.
- **Stray ready.** A `soc_side_ready_port` pulse outside WAIT_DONE is ignored.
- **Arbitration.** See Configuration.
  - `last_owner` updates on every issue.
  - Reset value of `last_owner` = 1, so m0 wins the first contention.
- **Non-winner.** A request not granted stays pending; its ack stays low.
- **Controller-side outputs.** Addr, data and mask hold their values after ISSUE until the next issue.
- **Reset (async, any state).** State = IDLE, `last_owner` = 1, counter = 0, and all outputs 0: acks, readys, rd_data, soc_side_* outputs and `timeout_err_port`. A transaction in flight is dropped and no ready is produced for it.

## Timing
- Request sampled in IDLE at cycle T (busy low) → command pulse and ack at T+1.
- Controller ready at cycle R → `m<owner>_ready_port` and rd_data at R+1.
- State returns to IDLE at R+1; the next issue is possible at R+2 at the earliest.
- Minimum spacing between command pulses: 3 cycles.
- If busy is high in IDLE, no issue occurs; the arbiter re-evaluates every cycle.
- Watchdog expiry: ready pulse exactly TIMEOUT_CYCLES cycles after the command pulse.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `SDRAM_ARB_ROUND_ROBIN_EN` defined: on contention, grant the master ≠ `last_owner`.
- Undefined: fixed priority, m0 always wins contention.
- Both settings: a single requester is granted immediately, and `last_owner` is still tracked.

## Test plan
- **m0 read alone.** m0 rd_en, addr 0x000123; controller ready 5 cycles after the command with data 0xDEADBEEF → `soc_side_rd_en_port` pulse with addr 0x000123; `m0_ack_port` at T+1; `m0_ready_port` with 0xDEADBEEF one cycle after the controller ready; no m1 pulses.
- **Simultaneous writes, round-robin.** m0 and m1 both wr_en, held continuously, with `SDRAM_ARB_ROUND_ROBIN_EN` defined → grant order m0, m1, m0, m1. Without the macro → m0, m0, m0.
- **Busy stall.** Busy high for 20 cycles while m1 requests → no command and no ack during the stall; command exactly 1 cycle after busy falls; mask 0b0101 seen on `soc_side_wr_mask_port`.
- **Watchdog.** TIMEOUT_CYCLES = 16, controller never asserts ready → `m0_ready_port` with rd_data 0 exactly 16 cycles after the command; `timeout_err_port` = 1 and stays 1; the next request is serviced normally.
- **Async reset in WAIT_DONE.** Assert `reset_n_port` between clock edges → all outputs 0 immediately. After release, a pending m1 request issues normally and the late controller ready is ignored.
- **Both enables.** m1 wr_en and rd_en both high → only `soc_side_wr_en_port` pulses.

Source files
------------

// File: rtl/sdram_arbiter.sv
// Two-master arbiter in front of sdram_controller: one outstanding command, watchdog on completion.
// Define SDRAM_ARB_ROUND_ROBIN_EN for round-robin on contention; default is fixed priority (m0 wins).
module sdram_arbiter #(
  parameter int ADDR_WIDTH     = 23,
  parameter int DATA_WIDTH     = 32,
  parameter int MASK_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset_n_port,
  input  logic [ADDR_WIDTH-1:0] m0_addr_port,
  input  logic [DATA_WIDTH-1:0] m0_wr_data_port,
  input  logic [MASK_WIDTH-1:0] m0_wr_mask_port,
  input  logic                  m0_wr_en_port,
  input  logic                  m0_rd_en_port,
  output logic                  m0_ack_port,
  output logic                  m0_ready_port,
  output logic [DATA_WIDTH-1:0] m0_rd_data_port,
  input  logic [ADDR_WIDTH-1:0] m1_addr_port,
  input  logic [DATA_WIDTH-1:0] m1_wr_data_port,
  input  logic [MASK_WIDTH-1:0] m1_wr_mask_port,
  input  logic                  m1_wr_en_port,
  input  logic                  m1_rd_en_port,
  output logic                  m1_ack_port,
  output logic                  m1_ready_port,
  output logic [DATA_WIDTH-1:0] m1_rd_data_port,
  input  logic                  soc_side_busy_port,
  input  logic                  soc_side_ready_port,
  input  logic [DATA_WIDTH-1:0] soc_side_rd_data_port,
  output logic [ADDR_WIDTH-1:0] soc_side_addr_port,
  output logic [DATA_WIDTH-1:0] soc_side_wr_data_port,
  output logic [MASK_WIDTH-1:0] soc_side_wr_mask_port,
  output logic                  soc_side_wr_en_port,
  output logic                  soc_side_rd_en_port,
  output logic                  timeout_err_port
);

  // state     | meaning
  // IDLE      | pick a winner, register the command
  // ISSUE     | command pulse and ack on the wire
  // WAIT_DONE | waiting for controller ready or watchdog expiry
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

  localparam int CW = $clog2(TIMEOUT_CYCLES);

  state_t        state, state_nxt;
  logic          last_owner, owner, is_write;
  logic [CW-1:0] wd_cnt;
  logic          req0, req1, grant1, win_wr;
  logic          issue_go, done_ok, done_to, expire;

  always_ff @(posedge clk or negedge reset_n_port) begin
    if (!reset_n_port) state <= IDLE;
    else               state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    issue_go  = 1'b0;
    done_ok   = 1'b0;
    done_to   = 1'b0;
    req0      = m0_wr_en_port | m0_rd_en_port;
    req1      = m1_wr_en_port | m1_rd_en_port;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    grant1    = req1 & (~req0 | ~last_owner);
`else
    grant1    = req1 & ~req0;
`endif
    win_wr    = grant1 ? m1_wr_en_port : m0_wr_en_port;
    expire    = (wd_cnt == CW'(TIMEOUT_CYCLES - 1));
    case (state)
      IDLE: begin
        if (!soc_side_busy_port && (req0 || req1)) begin
          issue_go  = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: state_nxt = WAIT_DONE;
      WAIT_DONE: begin
        if (soc_side_ready_port) begin
          done_ok   = 1'b1;
          state_nxt = IDLE;
        end else if (expire) begin
          done_to   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counter reads k in the k-th cycle after the command pulse, so expiry at
  // TIMEOUT_CYCLES-1 puts the registered ready exactly TIMEOUT_CYCLES after it.
  always_ff @(posedge clk or negedge reset_n_port) begin
    if (!reset_n_port) begin
      last_owner            <= 1'b1;
      owner                 <= 1'b0;
      is_write              <= 1'b0;
      wd_cnt                <= '0;
      m0_ack_port           <= 1'b0;
      m1_ack_port           <= 1'b0;
      m0_ready_port         <= 1'b0;
      m1_ready_port         <= 1'b0;
      m0_rd_data_port       <= '0;
      m1_rd_data_port       <= '0;
      soc_side_addr_port    <= '0;
      soc_side_wr_data_port <= '0;
      soc_side_wr_mask_port <= '0;
      soc_side_wr_en_port   <= 1'b0;
      soc_side_rd_en_port   <= 1'b0;
      timeout_err_port      <= 1'b0;
    end else begin
      m0_ack_port         <= 1'b0;
      m1_ack_port         <= 1'b0;
      m0_ready_port       <= 1'b0;
      m1_ready_port       <= 1'b0;
      soc_side_wr_en_port <= 1'b0;
      soc_side_rd_en_port <= 1'b0;

      if (issue_go)            wd_cnt <= '0;
      else if (state != IDLE)  wd_cnt <= wd_cnt + 1'b1;

      if (issue_go) begin
        owner                 <= grant1;
        last_owner            <= grant1;
        is_write              <= win_wr;
        soc_side_addr_port    <= grant1 ? m1_addr_port    : m0_addr_port;
        soc_side_wr_data_port <= grant1 ? m1_wr_data_port : m0_wr_data_port;
        soc_side_wr_mask_port <= grant1 ? m1_wr_mask_port : m0_wr_mask_port;
        soc_side_wr_en_port   <= win_wr;
        soc_side_rd_en_port   <= ~win_wr;
        m0_ack_port           <= ~grant1;
        m1_ack_port           <= grant1;
      end

      if (done_ok || done_to) begin
        if (owner) m1_ready_port <= 1'b1;
        else       m0_ready_port <= 1'b1;
      end

      if (done_ok && !is_write) begin
        if (owner) m1_rd_data_port <= soc_side_rd_data_port;
        else       m0_rd_data_port <= soc_side_rd_data_port;
      end

      if (done_to) begin
        timeout_err_port <= 1'b1;
        if (owner) m1_rd_data_port <= '0;
        else       m0_rd_data_port <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: vector table, scoreboard monitor, corner-case sequences.
module tb_sdram_arbiter;
  localparam int AW = 23;
  localparam int DW = 32;
  localparam int MW = 4;
  localparam int TO = 16;

  typedef struct {
    int          m;
    bit          wr;
    bit          rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [MW-1:0] mask;
    int          dly;
    logic [DW-1:0] rdata;
    bit          exp_wr;
    logic [DW-1:0] exp_rd;
  } vec_t;

  typedef struct {
    int          m;
    bit          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [MW-1:0] mask;
  } cmd_t;

  typedef struct {
    int          m;
    logic [DW-1:0] rd;
  } done_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [AW-1:0] m_addr [2];
  logic [DW-1:0] m_wdata[2];
  logic [MW-1:0] m_mask [2];
  logic          m_wr   [2];
  logic          m_rd   [2];
  logic          m_ack  [2];
  logic          m_ready[2];
  logic [DW-1:0] m_rdata[2];
  logic          busy, soc_ready;
  logic [DW-1:0] soc_rdata;
  logic [AW-1:0] soc_addr;
  logic [DW-1:0] soc_wdata;
  logic [MW-1:0] soc_mask;
  logic          soc_wr_en, soc_rd_en, timeout_err;

  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;
  cmd_t  cmd_q[$];
  done_t done_q[$];
  cmd_t  mon_c;
  done_t mon_d;

  sdram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n_port(rst_n),
    .m0_addr_port(m_addr[0]), .m0_wr_data_port(m_wdata[0]), .m0_wr_mask_port(m_mask[0]),
    .m0_wr_en_port(m_wr[0]), .m0_rd_en_port(m_rd[0]), .m0_ack_port(m_ack[0]),
    .m0_ready_port(m_ready[0]), .m0_rd_data_port(m_rdata[0]),
    .m1_addr_port(m_addr[1]), .m1_wr_data_port(m_wdata[1]), .m1_wr_mask_port(m_mask[1]),
    .m1_wr_en_port(m_wr[1]), .m1_rd_en_port(m_rd[1]), .m1_ack_port(m_ack[1]),
    .m1_ready_port(m_ready[1]), .m1_rd_data_port(m_rdata[1]),
    .soc_side_busy_port(busy), .soc_side_ready_port(soc_ready), .soc_side_rd_data_port(soc_rdata),
    .soc_side_addr_port(soc_addr), .soc_side_wr_data_port(soc_wdata), .soc_side_wr_mask_port(soc_mask),
    .soc_side_wr_en_port(soc_wr_en), .soc_side_rd_en_port(soc_rd_en), .timeout_err_port(timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every command pulse and every ready pulse must match the queue head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (soc_wr_en || soc_rd_en) begin
        if (cmd_q.size() == 0) chk("unexpected_cmd", 64'(cmd_q.size()), 1);
        else begin
          mon_c = cmd_q.pop_front();
          chk("cmd_wr_en", soc_wr_en, mon_c.wr);
          chk("cmd_rd_en", soc_rd_en, !mon_c.wr);
          chk("cmd_addr", soc_addr, mon_c.addr);
          chk("cmd_mask", soc_mask, mon_c.mask);
          if (mon_c.wr) chk("cmd_wr_data", soc_wdata, mon_c.data);
          chk("cmd_ack_owner", m_ack[mon_c.m], 1);
          chk("cmd_ack_other", m_ack[1-mon_c.m], 0);
        end
      end else if (m_ack[0] || m_ack[1]) begin
        chk("ack_without_cmd", {m_ack[1], m_ack[0]}, 0);
      end
      if (m_ready[0] || m_ready[1]) begin
        if (done_q.size() == 0) chk("unexpected_ready", 64'(done_q.size()), 1);
        else begin
          mon_d = done_q.pop_front();
          chk("ready_owner", m_ready[mon_d.m], 1);
          chk("ready_other", m_ready[1-mon_d.m], 0);
          chk("ready_rd_data", m_rdata[mon_d.m], mon_d.rd);
        end
      end
    end
  end

  task automatic wait_cmd(output int c);
    c = -1;
    for (int n = 0; n < 100; n++) begin
      if (soc_wr_en || soc_rd_en) begin
        c = cyc;
        break;
      end
      step();
    end
    if (c < 0) chk("cmd_wait_expired", {soc_wr_en, soc_rd_en}, 1);
  endtask

  // Controller model: ready dly cycles after the command, then check the owner's completion.
  task automatic complete(input int m, input int dly, input logic [DW-1:0] rdata,
                          input logic [DW-1:0] exp_rd);
    repeat (dly) step();
    soc_ready = 1'b1;
    soc_rdata = rdata;
    step();
    soc_ready = 1'b0;
    soc_rdata = '0;
    chk("ready_latency", m_ready[m], 1);
    chk("ready_data", m_rdata[m], exp_rd);
  endtask

  task automatic drive(input vec_t v);
    m_addr[v.m]  = v.addr;
    m_wdata[v.m] = v.data;
    m_mask[v.m]  = v.mask;
    m_wr[v.m]    = v.wr;
    m_rd[v.m]    = v.rd;
    cmd_q.push_back('{m: v.m, wr: v.exp_wr, addr: v.addr, data: v.data, mask: v.mask});
    done_q.push_back('{m: v.m, rd: v.exp_rd});
  endtask

  task automatic release_m(input int m);
    m_wr[m] = 1'b0;
    m_rd[m] = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int k, c;
    drive(v);
    k = cyc;
    wait_cmd(c);
    chk("issue_latency", 64'(c - k), 1);
    chk("ack_owner", m_ack[v.m], 1);
    release_m(v.m);
    complete(v.m, v.dly, v.rdata, v.exp_rd);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cmd_q.delete();
    done_q.delete();
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ack"}, {m_ack[1], m_ack[0]}, 0);
    chk({tag, "_ready"}, {m_ready[1], m_ready[0]}, 0);
    chk({tag, "_rd_data0"}, m_rdata[0], 0);
    chk({tag, "_rd_data1"}, m_rdata[1], 0);
    chk({tag, "_soc_addr"}, soc_addr, 0);
    chk({tag, "_soc_data_mask"}, {soc_wdata, soc_mask}, 0);
    chk({tag, "_soc_en"}, {soc_wr_en, soc_rd_en}, 0);
    chk({tag, "_timeout_err"}, timeout_err, 0);
  endtask

  vec_t vecs[6];
  vec_t v;
  int   c, k, p;
  int   order[4];

  initial begin
    vecs[0] = '{m:0, wr:0, rd:1, addr:23'h000123, data:32'h0, mask:4'h0, dly:5,
                rdata:32'hDEADBEEF, exp_wr:0, exp_rd:32'hDEADBEEF};
    vecs[1] = '{m:1, wr:1, rd:0, addr:23'h7FFFFF, data:32'h12345678, mask:4'hF, dly:1,
                rdata:32'h99999999, exp_wr:1, exp_rd:32'h0};
    vecs[2] = '{m:1, wr:0, rd:1, addr:23'h000000, data:32'h0, mask:4'h0, dly:3,
                rdata:32'hA5A5A5A5, exp_wr:0, exp_rd:32'hA5A5A5A5};
    vecs[3] = '{m:1, wr:1, rd:1, addr:23'h400000, data:32'hCAFEF00D, mask:4'h3, dly:2,
                rdata:32'h11111111, exp_wr:1, exp_rd:32'hA5A5A5A5};
    vecs[4] = '{m:0, wr:1, rd:0, addr:23'h000001, data:32'h0, mask:4'h0, dly:1,
                rdata:32'h22222222, exp_wr:1, exp_rd:32'hDEADBEEF};
    vecs[5] = '{m:0, wr:0, rd:1, addr:23'h2AAAAA, data:32'h0, mask:4'h0, dly:8,
                rdata:32'h0F0F0F0F, exp_wr:0, exp_rd:32'h0F0F0F0F};

    for (int i = 0; i < 2; i++) begin
      m_addr[i] = '0; m_wdata[i] = '0; m_mask[i] = '0; m_wr[i] = 1'b0; m_rd[i] = 1'b0;
    end
    busy = 1'b0; soc_ready = 1'b0; soc_rdata = '0; rst_n = 1'b0;
    repeat (3) step();
    check_all_zero("reset");
    rst_n = 1'b1;
    step();

    foreach (vecs[i]) run_vec(vecs[i]);

    // Busy stall: m1 masked write held off for 20 cycles.
    busy = 1'b1;
    drive('{m:1, wr:1, rd:0, addr:23'h0ABCDE, data:32'h55AA55AA, mask:4'b0101, dly:1,
            rdata:32'h0, exp_wr:1, exp_rd:32'hA5A5A5A5});
    for (int i = 0; i < 20; i++) begin
      step();
      chk("stall_no_ack", m_ack[1], 0);
      chk("stall_no_cmd", {soc_wr_en, soc_rd_en}, 0);
    end
    busy = 1'b0;
    k = cyc;
    wait_cmd(c);
    chk("stall_release_latency", 64'(c - k), 1);
    release_m(1);
    complete(1, 1, 32'h0, 32'hA5A5A5A5);

    // Watchdog: controller never answers.
    drive('{m:0, wr:0, rd:1, addr:23'h000003, data:32'h0, mask:4'h0, dly:0,
            rdata:32'h0, exp_wr:0, exp_rd:32'h0});
    wait_cmd(c);
    release_m(0);
    for (int i = 1; i < TO; i++) begin
      step();
      chk("wd_no_early_ready", m_ready[0], 0);
    end
    step();
    chk("wd_ready_at_timeout", m_ready[0], 1);
    chk("wd_rd_data_zero", m_rdata[0], 0);
    chk("wd_err_set", timeout_err, 1);
    chk("wd_cycles", 64'(cyc - c), TO);
    step();
    run_vec('{m:1, wr:0, rd:1, addr:23'h000010, data:32'h0, mask:4'h0, dly:4,
              rdata:32'h600DF00D, exp_wr:0, exp_rd:32'h600DF00D});
    chk("wd_err_sticky", timeout_err, 1);

    // Async reset while m0's read is in flight; m1 waits behind it.
    drive('{m:0, wr:0, rd:1, addr:23'h000777, data:32'h0, mask:4'h0, dly:0,
            rdata:32'h0, exp_wr:0, exp_rd:32'h0});
    wait_cmd(c);
    release_m(0);
    step();
    m_addr[1] = 23'h001234; m_rd[1] = 1'b1;
    step();
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    cmd_q.delete();
    done_q.delete();
    @(posedge clk);
    #3 rst_n = 1'b1;
    cmd_q.push_back('{m: 1, wr: 1'b0, addr: 23'h001234, data: '0, mask: '0});
    done_q.push_back('{m: 1, rd: 32'h13579BDF});
    soc_ready = 1'b1;
    soc_rdata = 32'hBAD0BAD0;
    p = cyc;
    wait_cmd(c);
    soc_ready = 1'b0;
    soc_rdata = '0;
    chk("post_reset_issue", 64'(c - p), 1);
    chk("stray_ready_ignored", {m_ready[1], m_ready[0]}, 0);
    release_m(1);
    complete(1, 2, 32'h13579BDF, 32'h13579BDF);
    chk("reset_cleared_err", timeout_err, 0);

    // Contention from reset: both masters hold write requests.
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    order = '{0, 1, 0, 1};
`else
    order = '{0, 0, 0, 0};
`endif
    do_reset();
    m_addr[0] = 23'h000100; m_wdata[0] = 32'hAAAA0000; m_mask[0] = 4'hF;
    m_addr[1] = 23'h000200; m_wdata[1] = 32'hBBBB0000; m_mask[1] = 4'hE;
    for (int i = 0; i < 4; i++) begin
      cmd_q.push_back('{m: order[i], wr: 1'b1, addr: m_addr[order[i]],
                        data: m_wdata[order[i]], mask: m_mask[order[i]]});
      done_q.push_back('{m: order[i], rd: 32'h0});
    end
    m_wr[0] = 1'b1; m_wr[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_cmd(c);
      chk($sformatf("grant_%0d", i), m_ack[1], order[i]);
      if (i == 3) begin
        release_m(0);
        release_m(1);
      end
      complete(order[i], 1, 32'h0, 32'h0);
    end
    repeat (5) step();
    chk("grant_queue_drained", 64'(cmd_q.size() + done_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
